// File: rtl/mem_port_arbiter.sv
// Two-way arbiter for the single axi_interface memory port.
// D-cache wins ties. An I request that has waited through MAX_D_STREAK
// consecutive D grants wins the next tie. The winning request is latched
// into the mem_* registers and held until mem_ready.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_strobe,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_strobe,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_size,
    input  logic [3:0]        d_sel,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              flush,
    output logic              mem_access,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_write,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_sel,
    output logic [DATA_W-1:0] mem_st_data,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_flush,
    output logic              grant_i
);

    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                discard_q, discard_d;

    logic                i_ready_q, i_ready_d;
    logic                d_ready_q, d_ready_d;
    logic [DATA_W-1:0]   i_rdata_d, d_rdata_d;
    logic                access_d;
    logic [ADDR_W-1:0]   mem_a_d;
    logic                mem_write_d;
    logic [1:0]          mem_size_d;
    logic [3:0]          mem_sel_d;
    logic [DATA_W-1:0]   mem_st_data_d;
    logic                grant_i_d;
    logic                i_starving;
    logic                take_d;

    // D wins unless the I side has waited out the full streak
    assign i_starving = i_strobe && (streak_q == STREAK_MAX);
    assign take_d     = d_strobe && !flush && !i_starving;

    // Flush must reach axi_interface and squash a ready pulse in the same cycle
    assign mem_flush = flush;
    assign i_ready   = i_ready_q && !flush;
    assign d_ready   = d_ready_q && !flush;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, grant latching and response routing
    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        discard_d     = discard_q;
        i_ready_d     = 1'b0;
        d_ready_d     = 1'b0;
        i_rdata_d     = i_rdata;
        d_rdata_d     = d_rdata;
        access_d      = mem_access;
        mem_a_d       = mem_a;
        mem_write_d   = mem_write;
        mem_size_d    = mem_size;
        mem_sel_d     = mem_sel;
        mem_st_data_d = mem_st_data;
        grant_i_d     = grant_i;

        unique case (state_q)
            IDLE: begin
                if (take_d) begin
                    state_d       = GNT_D;
                    access_d      = 1'b1;
                    mem_a_d       = d_addr;
                    mem_write_d   = d_rw;
                    mem_size_d    = d_size;
                    mem_sel_d     = d_sel;
                    mem_st_data_d = d_wdata;
                    if (i_strobe && (streak_q != STREAK_MAX)) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (i_strobe && !flush) begin
                    state_d       = GNT_I;
                    access_d      = 1'b1;
                    grant_i_d     = 1'b1;
                    mem_a_d       = i_addr;
                    mem_write_d   = 1'b0;
                    mem_size_d    = 2'b10;
                    mem_sel_d     = 4'b1111;
                    mem_st_data_d = '0;
                    streak_d      = '0;
                end
            end
            GNT_I, GNT_D: begin
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (mem_ready) begin
                    state_d   = DONE;
                    access_d  = 1'b0;
                    grant_i_d = 1'b0;
                    if (state_q == GNT_I) begin
                        i_rdata_d = mem_data;
                        i_ready_d = !(discard_q || flush);
                    end else begin
                        d_rdata_d = mem_data;
                        d_ready_d = !(discard_q || flush);
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                discard_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs and bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q    <= '0;
            discard_q   <= 1'b0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            mem_access  <= 1'b0;
            mem_a       <= '0;
            mem_write   <= 1'b0;
            mem_size    <= 2'b00;
            mem_sel     <= 4'b0000;
            mem_st_data <= '0;
            grant_i     <= 1'b0;
        end else begin
            streak_q    <= streak_d;
            discard_q   <= discard_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            i_rdata     <= i_rdata_d;
            d_rdata     <= d_rdata_d;
            mem_access  <= access_d;
            mem_a       <= mem_a_d;
            mem_write   <= mem_write_d;
            mem_size    <= mem_size_d;
            mem_sel     <= mem_sel_d;
            mem_st_data <= mem_st_data_d;
            grant_i     <= grant_i_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: per-side expected read data queues,
// a latency-programmable memory responder and a port monitor.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_strobe;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_strobe;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic [3:0]  d_sel;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        flush;
    logic        mem_access;
    logic [31:0] mem_a;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [3:0]  mem_sel;
    logic [31:0] mem_st_data;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        mem_flush;
    logic        grant_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 2;
    logic [31:0] sb_i[$];
    logic [31:0] sb_d[$];
    bit          grant_log[$];
    logic        gwr_log[$];
    int last_acc_len = 0;
    int last_d_rdy_cyc = 0;
    int last_gnt_i_cyc = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_strobe(i_strobe), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_strobe(d_strobe), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_sel(d_sel), .d_ready(d_ready), .d_rdata(d_rdata),
        .flush(flush), .mem_access(mem_access), .mem_a(mem_a), .mem_write(mem_write),
        .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
        .mem_ready(mem_ready), .mem_data(mem_data), .mem_flush(mem_flush),
        .grant_i(grant_i)
    );

    initial forever #5 clk = ~clk;

    // Memory contents seen through axi_interface
    function automatic logic [31:0] model(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C08_0001;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic run_cycles();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    // Answers each grant after lat cycles of mem_access
    task automatic run_responder();
        int rcyc = 0;
        forever begin
            @(negedge clk);
            if (mem_access && !mem_ready) begin
                rcyc++;
                if (rcyc >= lat) begin
                    mem_ready = 1'b1;
                    mem_data  = model(mem_a);
                end
            end else begin
                mem_ready = 1'b0;
                rcyc = 0;
            end
        end
    endtask

    // Port monitor: grant log, request stability, ready exclusivity, scoreboard
    task automatic run_monitor();
        bit          acc_prev = 0;
        int          acc_len = 0;
        logic [70:0] snap = '0;
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_prev = 0;
            end else begin
                if (mem_access && !acc_prev) begin
                    grant_log.push_back(grant_i);
                    gwr_log.push_back(mem_write);
                    snap = {mem_a, mem_write, mem_size, mem_sel, mem_st_data};
                    acc_len = 1;
                    if (grant_i) last_gnt_i_cyc = cyc;
                end else if (mem_access) begin
                    acc_len++;
                    checks++;
                    if ({mem_a, mem_write, mem_size, mem_sel, mem_st_data} !== snap) begin
                        errors++;
                        $display("FAIL mem_stable: got %h required %h",
                                 {mem_a, mem_write, mem_size, mem_sel, mem_st_data}, snap);
                    end
                end else if (acc_prev) begin
                    last_acc_len = acc_len;
                end
                acc_prev = mem_access;
                checks++;
                if (i_ready && d_ready) begin
                    errors++;
                    $display("FAIL one_ready: i_ready=%b d_ready=%b required not both", i_ready, d_ready);
                end
                if (i_ready) begin
                    checks++;
                    if (sb_i.size() == 0) begin
                        errors++;
                        $display("FAIL i_unexpected: i_ready=1 required 0 (no pending I request)");
                    end else begin
                        exp = sb_i.pop_front();
                        if (i_rdata !== exp) begin
                            errors++;
                            $display("FAIL i_rdata: got %h required %h", i_rdata, exp);
                        end
                    end
                end
                if (d_ready) begin
                    last_d_rdy_cyc = cyc;
                    checks++;
                    if (sb_d.size() == 0) begin
                        errors++;
                        $display("FAIL d_unexpected: d_ready=1 required 0 (no pending D request)");
                    end else begin
                        exp = sb_d.pop_front();
                        if (d_rdata !== exp) begin
                            errors++;
                            $display("FAIL d_rdata: got %h required %h", d_rdata, exp);
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_d_ready(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_ready && n < 100);
        checks++;
        if (!d_ready) begin
            errors++;
            $display("FAIL %s: d_ready=0 required 1 within 100 cycles", tag);
        end
    endtask

    task automatic wait_i_ready(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!i_ready && n < 100);
        checks++;
        if (!i_ready) begin
            errors++;
            $display("FAIL %s: i_ready=0 required 1 within 100 cycles", tag);
        end
    endtask

    task automatic wait_access(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_access && n < 20);
        checks++;
        if (!mem_access) begin
            errors++;
            $display("FAIL %s: mem_access=0 required 1 within 20 cycles", tag);
        end
    endtask

    task automatic serve_d(input logic [31:0] addr, input logic rw, input logic [31:0] wd);
        sb_d.push_back(model(addr));
        @(posedge clk); #1;
        d_strobe = 1'b1; d_addr = addr; d_rw = rw; d_wdata = wd;
        d_size = 2'b10; d_sel = 4'hF;
        wait_d_ready("serve_d");
        @(posedge clk); #1;
        d_strobe = 1'b0;
    endtask

    task automatic serve_i(input logic [31:0] addr);
        sb_i.push_back(model(addr));
        @(posedge clk); #1;
        i_strobe = 1'b1; i_addr = addr;
        wait_i_ready("serve_i");
        @(posedge clk); #1;
        i_strobe = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; mem_ready = 1'b0; mem_data = '0;
        i_strobe = 1'b0; i_addr = '0; d_strobe = 1'b0; d_rw = 1'b0; d_addr = '0;
        d_wdata = '0; d_size = 2'b00; d_sel = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({i_ready, i_rdata, d_ready, d_rdata, mem_access, mem_a, mem_write, mem_size,
             mem_sel, mem_st_data, mem_flush, grant_i} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: some output nonzero required all 0 (mem_access=%b mem_a=%h grant_i=%b)",
                     mem_access, mem_a, grant_i);
        end
        checks++;
        if (dut.state_q !== 2'd0 || dut.streak_q !== '0 || dut.discard_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d streak=%0d discard=%b required 0 0 0",
                     dut.state_q, dut.streak_q, dut.discard_q);
        end
        flush = 1'b1; #1;
        checks++;
        if (mem_flush !== 1'b1) begin
            errors++;
            $display("FAIL reset_mem_flush: got %b required 1", mem_flush);
        end
        flush = 1'b0; #1;
        checks++;
        if (mem_flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem_flush_low: got %b required 0", mem_flush);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_i_only();
        lat = 3;
        sb_i.push_back(32'h3C08_0001);
        @(posedge clk); #1;
        i_strobe = 1'b1; i_addr = 32'hBFC0_0000;
        wait_access("i_only_grant");
        checks++;
        if (mem_a !== 32'hBFC0_0000 || mem_size !== 2'b10 || mem_sel !== 4'hF ||
            mem_write !== 1'b0 || grant_i !== 1'b1) begin
            errors++;
            $display("FAIL i_only_req: a=%h size=%b sel=%b wr=%b gi=%b required bfc00000 10 1111 0 1",
                     mem_a, mem_size, mem_sel, mem_write, grant_i);
        end
        wait_i_ready("i_only_ready");
        checks++;
        if (i_rdata !== 32'h3C08_0001) begin
            errors++;
            $display("FAIL i_only_rdata: got %h required 3c080001", i_rdata);
        end
        @(posedge clk); #1;
        i_strobe = 1'b0;
        @(negedge clk);
        checks++;
        if (last_acc_len != 3) begin
            errors++;
            $display("FAIL i_only_access_len: got %0d required 3", last_acc_len);
        end
        checks++;
        if (i_ready !== 1'b0) begin
            errors++;
            $display("FAIL i_only_pulse_width: i_ready=%b required 0", i_ready);
        end
    endtask

    task automatic test_simultaneous();
        lat = 2;
        grant_log.delete(); gwr_log.delete();
        fork
            serve_d(32'h1FAF_0000, 1'b1, 32'hDEAD_BEEF);
            serve_i(32'h0040_0000);
        join
        checks++;
        if (grant_log.size() < 2) begin
            errors++;
            $display("FAIL simul_grants: got %0d grants required 2", grant_log.size());
        end else begin
            checks++;
            if (grant_log[0] !== 1'b0 || gwr_log[0] !== 1'b1 || grant_log[1] !== 1'b1) begin
                errors++;
                $display("FAIL simul_order: first=%b wr=%b second=%b required D(0) 1 I(1)",
                         grant_log[0], gwr_log[0], grant_log[1]);
            end
        end
        checks++;
        if (last_gnt_i_cyc - last_d_rdy_cyc != 2) begin
            errors++;
            $display("FAIL simul_i_delay: got %0d cycles required 2", last_gnt_i_cyc - last_d_rdy_cyc);
        end
    endtask

    task automatic test_starvation();
        bit exp_side[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        lat = 1;
        grant_log.delete(); gwr_log.delete();
        fork
            serve_i(32'h0040_1000);
            begin
                @(posedge clk); #1;
                d_strobe = 1'b1; d_rw = 1'b0; d_size = 2'b10; d_sel = 4'hF;
                for (int k = 0; k < 5; k++) begin
                    d_addr = 32'h0000_2000 + 32'(k) * 32'd4;
                    sb_d.push_back(model(d_addr));
                    wait_d_ready("starve_d");
                    @(posedge clk); #1;
                end
                d_strobe = 1'b0;
            end
        join
        checks++;
        if (grant_log.size() < 5) begin
            errors++;
            $display("FAIL starve_grants: got %0d grants required at least 5", grant_log.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (grant_log[k] !== exp_side[k]) begin
                    errors++;
                    $display("FAIL starve_grant%0d: got side %b required %b (1=I)", k, grant_log[k], exp_side[k]);
                end
            end
        end
        checks++;
        if (dut.streak_q !== '0) begin
            errors++;
            $display("FAIL starve_streak: got %0d required 0", dut.streak_q);
        end
    endtask

    task automatic test_flush_mid();
        lat = 3;
        @(posedge clk); #1;
        d_strobe = 1'b1; d_addr = 32'h0000_3000; d_rw = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1; d_strobe = 1'b0;
        #1;
        checks++;
        if (mem_flush !== 1'b1 || mem_access !== 1'b1) begin
            errors++;
            $display("FAIL flush_mid_port: mem_flush=%b mem_access=%b required 1 1", mem_flush, mem_access);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (d_ready !== 1'b0) begin
                errors++;
                $display("FAIL flush_mid_no_ready: d_ready=%b required 0", d_ready);
            end
        end
        checks++;
        if (last_acc_len != 3) begin
            errors++;
            $display("FAIL flush_mid_access_len: got %0d required 3", last_acc_len);
        end
        serve_d(32'h0000_3004, 1'b0, 32'h0);
    endtask

    task automatic test_flush_done();
        int n = 0;
        lat = 2;
        @(posedge clk); #1;
        d_strobe = 1'b1; d_addr = 32'h0000_3008; d_rw = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ready && n < 20);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_done_no_ready: d_ready=%b required 0", d_ready);
        end
        checks++;
        if (d_rdata !== model(32'h0000_3008)) begin
            errors++;
            $display("FAIL flush_done_rdata: got %h required %h", d_rdata, model(32'h0000_3008));
        end
        @(posedge clk); #1;
        flush = 1'b0; d_strobe = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        lat = 4;
        @(posedge clk); #1;
        i_strobe = 1'b1; i_addr = 32'h0000_5000;
        do begin
            @(negedge clk);
            n++;
        end while (!grant_i && n < 20);
        rst = 1'b1;
        #1;
        checks++;
        if (mem_access !== 1'b0 || grant_i !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: mem_access=%b grant_i=%b required 0 0", mem_access, grant_i);
        end
        i_strobe = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (dut.state_q !== 2'd0 || mem_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_state: state=%0d mem_a=%h required 0 0", dut.state_q, mem_a);
        end
        serve_i(32'h0000_5004);
    endtask

    task automatic test_stability();
        int n = 0;
        lat = 3;
        sb_d.push_back(model(32'h0000_0100));
        @(posedge clk); #1;
        d_strobe = 1'b1; d_addr = 32'h0000_0100; d_rw = 1'b0;
        wait_access("stab_grant");
        d_addr = 32'h0000_0200;
        while (mem_access && n < 20) begin
            checks++;
            if (mem_a !== 32'h0000_0100) begin
                errors++;
                $display("FAIL stab_mem_a: got %h required 00000100", mem_a);
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (d_ready !== 1'b1) begin
            errors++;
            $display("FAIL stab_ready: d_ready=%b required 1", d_ready);
        end
        @(posedge clk); #1;
        d_strobe = 1'b0;
    endtask

    initial begin
        fork
            run_cycles();
            run_responder();
            run_monitor();
        join_none
        test_reset();
        test_i_only();
        test_simultaneous();
        test_starvation();
        test_flush_mid();
        test_flush_done();
        test_reset_mid();
        test_stability();
        repeat (4) @(posedge clk);
        checks++;
        if (sb_i.size() != 0 || sb_d.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: pending i=%0d d=%0d required 0 0", sb_i.size(), sb_d.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
